// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM responder.
// Supports byte, halfword and word accesses, a configurable number of wait
// states per OKAY transfer, and a two-cycle ERROR response for accesses that
// are oversized, misaligned or beyond the end of the array.
module ahb_sram_slave #(
  parameter int MEM_DEPTH   = 1024,
  parameter int REGION_BITS = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hmastlock,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic [15:0] hsplit
);

  // AW indexes words; OW is the byte-offset width actually backed by storage.
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int OW = AW + 2;
  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [OW-1:0] r_addr_q;
  logic        r_write_q;
  logic [1:0]  r_size_q;
  logic        r_dphase;
  logic        r_hreadyout;
  logic [1:0]  r_hresp;

  logic [31:0] r_mem [MEM_DEPTH];

  logic        w_accept;
  logic        w_size_bad;
  logic        w_misalign;
  logic        w_oor;
  logic        w_illegal;
  logic        w_complete;
  logic        w_commit;
  logic [3:0]  w_be;
  logic [AW-1:0] w_idx;
  logic        w_unused;

  // A new address phase may only be taken in states where this slave is
  // driving hreadyout high (IDLE, including a completing data phase, or ERR2).
  assign w_accept = hsel & hready & htrans[1] &
                    ((r_state == S_IDLE) | (r_state == S_ERR2));

  assign w_size_bad = (hsize > 3'd2);
  assign w_misalign = ((hsize == 3'd1) & haddr[0]) |
                      ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
  // Any offset bit above the backed range means the access runs off the end.
  assign w_oor      = ((haddr[REGION_BITS-1:0] >> OW) != '0);
  assign w_illegal  = w_size_bad | w_misalign | w_oor;

  // The completing cycle of a legal transfer is the IDLE cycle with dphase set.
  assign w_complete = r_dphase & (r_state == S_IDLE);
  assign w_commit   = w_complete & r_write_q;
  assign w_idx      = r_addr_q[OW-1:2];

  // Little-endian byte-lane enables for the captured transfer.
  always_comb begin
    w_be = 4'b0000;
    case (r_size_q)
      2'd0:    w_be[r_addr_q[1:0]] = 1'b1;
      2'd1:    w_be = r_addr_q[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Transfer FSM: captures control on acceptance, sequences wait/error cycles
  // and registers hreadyout/hresp for the following cycle.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr_q    <= '0;
      r_write_q   <= 1'b0;
      r_size_q    <= 2'd0;
      r_dphase    <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= RESP_OKAY;
    end else begin
      case (r_state)
        S_IDLE, S_ERR2: begin
          r_state     <= S_IDLE;
          r_dphase    <= 1'b0;
          r_hreadyout <= 1'b1;
          r_hresp     <= RESP_OKAY;
          if (w_accept) begin
            r_addr_q  <= haddr[OW-1:0];
            r_write_q <= hwrite;
            r_size_q  <= hsize[1:0];
            if (w_illegal) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= RESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              r_state     <= S_WAIT;
              r_cnt       <= WS_M1;
              r_dphase    <= 1'b1;
              r_hreadyout <= 1'b0;
            end else begin
              r_dphase    <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= RESP_ERROR;
        end
        default: begin
          r_state     <= S_IDLE;
          r_dphase    <= 1'b0;
          r_hreadyout <= 1'b1;
          r_hresp     <= RESP_OKAY;
        end
      endcase
    end
  end

  // Storage is never reset; writes land on the edge closing the data phase.
  // r_dphase is held clear during reset, so an aborted write never commits.
  always_ff @(posedge hclk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  // Full word straight from the array so a back-to-back read sees the write
  // committed on the previous edge.
  assign hrdata    = (w_complete & ~r_write_q) ? r_mem[w_idx] : 32'd0;
  assign hsplit    = 16'd0;

  assign w_unused  = ^{haddr[31:REGION_BITS], htrans[0], hburst, hprot, hmastlock};

endmodule
